qubit_beam_scheduler: RTL and testbench

Arbitrates qubit-addressing requests from the gate sequencer and the calibration engine. Each granted request is turned into a beam-steering operation on the 10x10 atom grid. For each request the block derives the qubit's (x, y) pixel coordinate sequentially from its index, hands the coordinate to the deflector driver, waits for a settle interval, then holds the beam on for the requested dwell. It sits between the sequencers and the deflector/laser-gate outputs.

---
 rtl/qubit_beam_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_qubit_beam_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qubit_beam_scheduler.sv
// qubit_beam_scheduler: round-robin arbiter between the gate sequencer and
// the calibration engine. It turns each granted qubit index into a grid
// coordinate, hands that coordinate to the deflector, waits for the beam to
// settle, then gates the laser on for the requested dwell.
module qubit_beam_scheduler #(
  parameter int NUM_QUBITS    = 100,
  parameter int GRID_COLS     = 10,
  parameter int COORD_WIDTH   = 10,
  parameter int QUBIT_START_X = 100,
  parameter int QUBIT_START_Y = 100,
  parameter int QUBIT_SPACING = 20,
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_gate_valid,
  output logic                   o_gate_ready,
  input  logic [6:0]             i_gate_idx,
  input  logic [DWELL_WIDTH-1:0] i_gate_dwell,
  input  logic                   i_cal_valid,
  output logic                   o_cal_ready,
  input  logic [6:0]             i_cal_idx,
  input  logic [DWELL_WIDTH-1:0] i_cal_dwell,
  input  logic                   i_abort,
  output logic                   o_move_valid,
  input  logic                   i_move_ack,
  output logic [COORD_WIDTH-1:0] o_beam_x,
  output logic [COORD_WIDTH-1:0] o_beam_y,
  output logic                   o_beam_on,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_aborted,
  output logic                   o_src,
  output logic [6:0]             o_idx
);

  localparam int IDX_W = 7;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = (DWELL_WIDTH > SET_W) ? DWELL_WIDTH : SET_W;

  localparam logic [IDX_W-1:0] COLS_L = IDX_W'(GRID_COLS);
  localparam logic [IDX_W:0]   NUMQ_L = (IDX_W + 1)'(NUM_QUBITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_MOVE,
    S_SETTLE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  // Latched request and working registers
  logic                   r_last_cal;
  logic                   r_src;
  logic [IDX_W-1:0]       r_idx;
  logic [DWELL_WIDTH-1:0] r_dwell;
  logic [IDX_W-1:0]       r_rem;
  logic [IDX_W-1:0]       r_row;
  logic [CNT_W-1:0]       r_cnt;
  logic [COORD_WIDTH-1:0] r_beam_x;
  logic [COORD_WIDTH-1:0] r_beam_y;

  // Registered strobes and their next-cycle values
  logic                   r_move_valid;
  logic                   r_beam_on;
  logic                   r_done;
  logic                   r_err;
  logic                   r_aborted;
  logic                   w_move_valid_nxt;
  logic                   w_beam_on_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;
  logic                   w_aborted_nxt;

  logic                   w_idle;
  logic                   w_gate_grant;
  logic                   w_cal_grant;
  logic                   w_grant;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [DWELL_WIDTH-1:0] w_sel_dwell;
  logic                   w_bad_idx;
  logic                   w_active;
  logic                   w_abort;
  logic                   w_row_found;
  logic                   w_cnt_zero;
  logic [COORD_WIDTH-1:0] w_x;
  logic [COORD_WIDTH-1:0] w_y;

  assign w_idle       = (r_state == S_IDLE);
  assign o_gate_ready = w_idle;
  assign o_cal_ready  = w_idle;

  // On a tie, the port that was not granted last time wins.
  assign w_gate_grant = w_idle & i_gate_valid & (~i_cal_valid | r_last_cal);
  assign w_cal_grant  = w_idle & i_cal_valid  & (~i_gate_valid | ~r_last_cal);
  assign w_grant      = w_gate_grant | w_cal_grant;
  assign w_sel_idx    = w_cal_grant ? i_cal_idx   : i_gate_idx;
  assign w_sel_dwell  = w_cal_grant ? i_cal_dwell : i_gate_dwell;
  assign w_bad_idx    = ({1'b0, w_sel_idx} >= NUMQ_L);

  assign w_active     = (r_state == S_CALC) || (r_state == S_MOVE) ||
                        (r_state == S_SETTLE) || (r_state == S_DWELL);
  assign w_abort      = i_abort & w_active;
  assign w_row_found  = (r_rem < COLS_L);
  assign w_cnt_zero   = (r_cnt == '0);

  // Once the row walk ends, rem is the column; sums wrap modulo 2^COORD_WIDTH.
  assign w_x = COORD_WIDTH'(QUBIT_START_X) +
               COORD_WIDTH'(r_rem) * COORD_WIDTH'(QUBIT_SPACING);
  assign w_y = COORD_WIDTH'(QUBIT_START_Y) +
               COORD_WIDTH'(r_row) * COORD_WIDTH'(QUBIT_SPACING);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    // NOTE: default first so that no path through the case leaves the
    // variable unassigned, which would infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = w_bad_idx ? S_IDLE : S_CALC;
      S_CALC:   if (w_abort) w_state_nxt = S_IDLE;
                else if (w_row_found) w_state_nxt = S_MOVE;
      S_MOVE:   if (w_abort) w_state_nxt = S_IDLE;
                else if (i_move_ack) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_abort) w_state_nxt = S_IDLE;
                else if (w_cnt_zero)
                  w_state_nxt = (r_dwell == '0) ? S_DONE : S_DWELL;
      S_DWELL:  if (w_abort) w_state_nxt = S_IDLE;
                else if (w_cnt_zero) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe
  always_comb begin
    w_move_valid_nxt = (w_state_nxt == S_MOVE);
    w_beam_on_nxt    = (w_state_nxt == S_DWELL);
    w_done_nxt       = (w_state_nxt == S_DONE);
    w_err_nxt        = w_grant & w_bad_idx;
    w_aborted_nxt    = w_abort;
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_move_valid <= 1'b0;
      r_beam_on    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_move_valid <= w_move_valid_nxt;
      r_beam_on    <= w_beam_on_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  // Request latch, row/column walk, coordinate and settle/dwell counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_cal <= 1'b1;
      r_src      <= 1'b0;
      r_idx      <= '0;
      r_dwell    <= '0;
      r_rem      <= '0;
      r_row      <= '0;
      r_cnt      <= '0;
      r_beam_x   <= '0;
      r_beam_y   <= '0;
    end else begin
      if (w_grant) begin
        r_last_cal <= w_cal_grant;
        r_src      <= w_cal_grant;
        r_idx      <= w_sel_idx;
        r_dwell    <= w_sel_dwell;
        r_rem      <= w_sel_idx;
        r_row      <= '0;
      end
      if (!w_abort) begin
        unique case (r_state)
          S_CALC: begin
            if (w_row_found) begin
              r_beam_x <= w_x;
              r_beam_y <= w_y;
            end else begin
              r_rem <= r_rem - COLS_L;
              r_row <= r_row + IDX_W'(1);
            end
          end
          S_MOVE:   if (i_move_ack) r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
          S_SETTLE: r_cnt <= w_cnt_zero ? (CNT_W'(r_dwell) - CNT_W'(1))
                                        : (r_cnt - CNT_W'(1));
          S_DWELL:  r_cnt <= r_cnt - CNT_W'(1);
          default:  ;
        endcase
      end
    end
  end

  assign o_move_valid = r_move_valid;
  assign o_beam_on    = r_beam_on;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_aborted    = r_aborted;
  assign o_beam_x     = r_beam_x;
  assign o_beam_y     = r_beam_y;
  assign o_src        = r_src;
  assign o_idx        = r_idx;

endmodule

// File: tb/tb_qubit_beam_scheduler.sv
// Bench for qubit_beam_scheduler: directed scenarios plus randomized requests,
// each operation checked against a timeline derived from the qubit's grid
// position (row = idx / cols, col = idx % cols) and the requested dwell.
module tb_qubit_beam_scheduler;

  localparam int NQ     = 100;
  localparam int COLS   = 10;
  localparam int CW     = 10;
  localparam int X0     = 100;
  localparam int Y0     = 100;
  localparam int PITCH  = 20;
  localparam int SETTLE = 8;
  localparam int DW     = 16;
  localparam int BUDGET = 400;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_gate_valid = 1'b0;
  logic          o_gate_ready;
  logic [6:0]    i_gate_idx = '0;
  logic [DW-1:0] i_gate_dwell = '0;
  logic          i_cal_valid = 1'b0;
  logic          o_cal_ready;
  logic [6:0]    i_cal_idx = '0;
  logic [DW-1:0] i_cal_dwell = '0;
  logic          i_abort = 1'b0;
  logic          o_move_valid;
  logic          i_move_ack = 1'b0;
  logic [CW-1:0] o_beam_x;
  logic [CW-1:0] o_beam_y;
  logic          o_beam_on;
  logic          o_done;
  logic          o_err;
  logic          o_aborted;
  logic          o_src;
  logic [6:0]    o_idx;

  qubit_beam_scheduler #(
    .NUM_QUBITS(NQ), .GRID_COLS(COLS), .COORD_WIDTH(CW),
    .QUBIT_START_X(X0), .QUBIT_START_Y(Y0), .QUBIT_SPACING(PITCH),
    .SETTLE_CYCLES(SETTLE), .DWELL_WIDTH(DW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_gate_valid(i_gate_valid), .o_gate_ready(o_gate_ready),
    .i_gate_idx(i_gate_idx), .i_gate_dwell(i_gate_dwell),
    .i_cal_valid(i_cal_valid), .o_cal_ready(o_cal_ready),
    .i_cal_idx(i_cal_idx), .i_cal_dwell(i_cal_dwell),
    .i_abort(i_abort), .o_move_valid(o_move_valid), .i_move_ack(i_move_ack),
    .o_beam_x(o_beam_x), .o_beam_y(o_beam_y), .o_beam_on(o_beam_on),
    .o_done(o_done), .o_err(o_err), .o_aborted(o_aborted),
    .o_src(o_src), .o_idx(o_idx)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: who was granted last, and the coordinate last computed
  bit m_last_cal = 1'b1;
  int m_x = 0;
  int m_y = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Issue one request (called at a negedge with the DUT idle) and follow the
  // resulting operation to its end, checking it against the expected timeline.
  task automatic run_op(input bit gv, input int gidx, input int gdw,
                        input bit cv, input int cidx, input int cdw,
                        input int ack_d, input int abort_req, input bit noise);
    bit win_cal;
    bit stable;
    int idx, dw, row, col, ex, ey, abort_at;
    int n, first_move, move_cnt, first_beam, beam_cnt, done_n, err_n, abort_n;

    win_cal    = (gv && cv) ? !m_last_cal : cv;
    m_last_cal = win_cal;
    idx        = win_cal ? cidx : gidx;
    dw         = win_cal ? cdw : gdw;
    row        = idx / COLS;
    col        = idx % COLS;
    ex         = (X0 + col * PITCH) % (1 << CW);
    ey         = (Y0 + row * PITCH) % (1 << CW);
    abort_at   = (abort_req > 0 && abort_req <= dw) ? abort_req : 0;

    check("ready_idle", 32'(o_gate_ready & o_cal_ready), 32'd1);
    i_gate_valid = gv;  i_gate_idx = 7'(gidx); i_gate_dwell = DW'(gdw);
    i_cal_valid  = cv;  i_cal_idx  = 7'(cidx); i_cal_dwell  = DW'(cdw);
    i_abort      = noise;  // abort in IDLE must be ignored
    i_move_ack   = noise;
    @(posedge i_clk);
    @(negedge i_clk);
    i_gate_valid = 1'b0;
    i_cal_valid  = 1'b0;

    stable = 1'b1;
    first_move = -1; move_cnt = 0; first_beam = -1; beam_cnt = 0;
    done_n = 0; err_n = 0; abort_n = 0;
    for (n = 1; n <= BUDGET; n++) begin
      i_move_ack = 1'b0;
      i_abort    = 1'b0;
      if (o_move_valid) begin
        if (first_move < 0) first_move = n;
        move_cnt++;
        if (o_beam_x !== CW'(ex) || o_beam_y !== CW'(ey)) stable = 1'b0;
        if (move_cnt == ack_d + 1) i_move_ack = 1'b1;
      end else if (noise) begin
        i_move_ack = 1'($urandom_range(0, 1));
      end
      if (o_beam_on) begin
        if (first_beam < 0) first_beam = n;
        beam_cnt++;
        if (abort_at > 0 && beam_cnt == abort_at) i_abort = 1'b1;
      end
      if (o_done)    done_n  = n;
      if (o_err)     err_n   = n;
      if (o_aborted) abort_n = n;
      if (done_n > 0 || err_n > 0 || abort_n > 0) break;
      @(negedge i_clk);
    end
    i_move_ack = 1'b0;
    i_abort    = 1'b0;

    if (n > BUDGET) check("op_timeout", 32'd0, 32'd1);
    check("src", 32'(o_src), 32'(win_cal));
    check("idx", 32'(o_idx), 32'(idx));

    if (idx >= NQ) begin
      check("err_cycle", 32'(err_n), 32'd1);
      check("err_no_move", 32'(move_cnt), 32'd0);
      check("err_no_done", 32'(done_n), 32'd0);
      check("err_ready", 32'(o_gate_ready), 32'd1);
    end else begin
      m_x = ex;
      m_y = ey;
      check("calc_len", 32'(first_move), 32'(row + 2));
      check("move_len", 32'(move_cnt), 32'(ack_d + 1));
      check("move_stable", 32'(stable), 32'd1);
      check("no_err", 32'(err_n), 32'd0);
      if (abort_at > 0) begin
        check("abort_beam_cnt", 32'(beam_cnt), 32'(abort_at));
        check("abort_cycle", 32'(abort_n), 32'(first_beam + abort_at));
        check("abort_no_done", 32'(done_n), 32'd0);
        check("abort_beam_off", 32'(o_beam_on), 32'd0);
        check("abort_ready", 32'(o_cal_ready), 32'd1);
      end else begin
        check("beam_cnt", 32'(beam_cnt), 32'(dw));
        check("done_cycle", 32'(done_n), 32'(row + 3 + ack_d + SETTLE + dw));
        check("no_abort", 32'(abort_n), 32'd0);
        @(negedge i_clk);
        check("done_pulse", 32'(o_done), 32'd0);
        check("ready_after_done", 32'(o_gate_ready), 32'd1);
      end
    end
    check("hold_x", 32'(o_beam_x), 32'(m_x));
    check("hold_y", 32'(o_beam_y), 32'(m_y));
  endtask

  initial begin
    bit gv, cv;
    int seen;

    // Reset values
    #12;
    check("rst_ready", 32'({o_gate_ready, o_cal_ready}), 32'd3);
    check("rst_outs", 32'({o_move_valid, o_beam_on, o_done, o_err, o_aborted, o_src}), 32'd0);
    check("rst_coord", 32'({o_beam_x, o_beam_y, o_idx}), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Both ports valid: gate, cal, gate; idx 99 lands on (280,280)
    run_op(1, 0, 3, 1, 99, 2, 0, 0, 0);
    run_op(1, 0, 3, 1, 99, 2, 0, 0, 0);
    check("idx99_xy", 32'({o_beam_x, o_beam_y}), 32'({10'd280, 10'd280}));
    run_op(1, 0, 3, 1, 99, 2, 0, 0, 0);

    // idx 23 dwell 5, immediate ack: (160,140)
    run_op(1, 23, 5, 0, 0, 0, 0, 0, 0);
    check("idx23_xy", 32'({o_beam_x, o_beam_y}), 32'({10'd160, 10'd140}));

    // Bad index, then idx 9 with zero dwell: (280,100)
    run_op(1, 100, 4, 0, 0, 0, 0, 0, 0);
    run_op(1, 9, 0, 0, 0, 0, 0, 0, 0);
    check("idx9_xy", 32'({o_beam_x, o_beam_y}), 32'({10'd280, 10'd100}));

    // Deflector ack delayed by 4 cycles
    run_op(1, 45, 3, 0, 0, 0, 4, 0, 0);

    // Abort in the 3rd of 10 dwell cycles
    run_op(1, 12, 10, 0, 0, 0, 0, 3, 0);

    // Randomized requests with stray ack/abort outside their windows
    for (int k = 0; k < 30; k++) begin
      gv = 1'($urandom_range(0, 1));
      cv = gv ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(gv, int'($urandom_range(0, 127)), int'($urandom_range(0, 12)),
             cv, int'($urandom_range(0, 127)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 5)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0,
             1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a dwell
    i_gate_valid = 1'b1; i_gate_idx = 7'd5; i_gate_dwell = DW'(10);
    @(posedge i_clk);
    @(negedge i_clk);
    i_gate_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < BUDGET; n++) begin
      i_move_ack = o_move_valid;
      if (o_beam_on) begin
        seen = 1;
        break;
      end
      @(negedge i_clk);
    end
    i_move_ack = 1'b0;
    check("pre_rst_beam_on", 32'(seen), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_beam", 32'(o_beam_on), 32'd0);
    check("async_rst_ready", 32'(o_gate_ready), 32'd1);
    check("async_rst_outs", 32'({o_move_valid, o_done, o_src, o_idx, o_beam_x}), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_last_cal = 1'b1;
    m_x = 0;
    m_y = 0;
    @(negedge i_clk);
    run_op(1, 7, 2, 1, 50, 3, 0, 0, 0);
    check("post_rst_gate_wins", 32'(o_src), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
